rv32i_mem_arbiter: RTL

Shares one single-port unified memory between the RV32I instruction-fetch path and the load/store path of the multi-cycle core. It accepts held-request transactions from both requesters and serialises them onto one memory bus with a variable-latency ack. It returns read data and a completion pulse to the winning requester. It also applies a watchdog so that a missing ack cannot hang the core.

---
 rtl/rv32i_arb_pkg.sv | 15 +
 rtl/rv32i_arb_wdt.sv | 41 ++++
 rtl/rv32i_mem_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rv32i_arb_pkg.sv
// rtl/rv32i_arb_pkg.sv - shared types and sizing helpers for the RV32I memory arbiter
package rv32i_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} arb_state_e;
    typedef enum logic {GNT_I, GNT_D} grant_e;

    // A zero timeout keeps a 1-bit counter width so ports never collapse to zero width.
    function automatic int wdt_w(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

    localparam int TIMEOUT_CYC_DEF = 255;
    localparam int WDT_W = wdt_w(TIMEOUT_CYC_DEF);

endpackage

// File: rtl/rv32i_arb_wdt.sv
// rtl/rv32i_arb_wdt.sv - clear/enable busy-cycle counter with terminal-count flag
module rv32i_arb_wdt #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            assign tc_o = 1'b0;
        end else begin : g_on
            logic [CNT_W-1:0] cnt_q, cnt_d;

            // cnt_q equals completed busy cycles, so the flag marks the TIMEOUT_CYC-th one.
            assign tc_o = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

            always_comb begin
                cnt_d = cnt_q;
                if (clr_i) begin
                    cnt_d = '0;
                end else if (en_i && !tc_o) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// rtl/rv32i_mem_arbiter.sv - fetch/load-store arbiter onto one memory port; MEM_ARB_RR_EN selects round-robin ties
module rv32i_mem_arbiter
    import rv32i_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iIReq,
    input  logic [ADDR_W-1:0]   iIAddr,
    output logic [DATA_W-1:0]   oIRdata,
    output logic                oIValid,
    output logic                oIErr,
    input  logic                iDReq,
    input  logic                iDWe,
    input  logic [ADDR_W-1:0]   iDAddr,
    input  logic [DATA_W-1:0]   iDWdata,
    input  logic [DATA_W/8-1:0] iDBe,
    output logic [DATA_W-1:0]   oDRdata,
    output logic                oDValid,
    output logic                oDErr,
    output logic                oMem_Req,
    output logic                oMem_We,
    output logic [ADDR_W-1:0]   oMem_Addr,
    output logic [DATA_W-1:0]   oMem_Wdata,
    output logic [DATA_W/8-1:0] oMem_Be,
    input  logic [DATA_W-1:0]   iMem_Rdata,
    input  logic                iMem_Ack
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = wdt_w(TIMEOUT_CYC);

    arb_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic              i_valid_q, i_valid_d, i_err_q, i_err_d;
    logic              d_valid_q, d_valid_d, d_err_q, d_err_d;
    grant_e            gnt;
    logic              busy, wdt_tc;

    assign busy = (state_q == BUSY_I) || (state_q == BUSY_D);

    rv32i_arb_wdt #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) u_wdt (
        .clk_i (iClk),
        .rst_ni(iRst),
        .clr_i (!busy),
        .en_i  (busy),
        .tc_o  (wdt_tc)
    );

`ifdef MEM_ARB_RR_EN
    grant_e last_q;

    always_comb begin
        if (iDReq && iIReq) begin
            gnt = (last_q == GNT_D) ? GNT_I : GNT_D;
        end else begin
            gnt = iDReq ? GNT_D : GNT_I;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            last_q <= GNT_D;
        end else if (state_q == IDLE && (iIReq || iDReq)) begin
            last_q <= gnt;
        end
    end
`else
    assign gnt = iDReq ? GNT_D : GNT_I;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_valid_d   = 1'b0;
        i_err_d     = 1'b0;
        d_valid_d   = 1'b0;
        d_err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (iIReq || iDReq) begin
                    mem_req_d = 1'b1;
                    if (gnt == GNT_D) begin
                        mem_we_d    = iDWe;
                        mem_addr_d  = iDAddr;
                        mem_wdata_d = iDWdata;
                        mem_be_d    = iDBe;
                        state_d     = BUSY_D;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = iIAddr;
                        mem_wdata_d = '0;
                        mem_be_d    = '1;
                        state_d     = BUSY_I;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                // Ack is tested first so a same-cycle timeout never flags an error.
                if (iMem_Ack) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    if (state_q == BUSY_I) begin
                        i_rdata_d = iMem_Rdata;
                        i_valid_d = 1'b1;
                    end else begin
                        if (!mem_we_q) begin
                            d_rdata_d = iMem_Rdata;
                        end
                        d_valid_d = 1'b1;
                    end
                end else if (wdt_tc) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    if (state_q == BUSY_I) begin
                        i_rdata_d = '0;
                        i_valid_d = 1'b1;
                        i_err_d   = 1'b1;
                    end else begin
                        d_rdata_d = '0;
                        d_valid_d = 1'b1;
                        d_err_d   = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_valid_q   <= 1'b0;
            i_err_q     <= 1'b0;
            d_valid_q   <= 1'b0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_valid_q   <= i_valid_d;
            i_err_q     <= i_err_d;
            d_valid_q   <= d_valid_d;
            d_err_q     <= d_err_d;
        end
    end

    assign oMem_Req   = mem_req_q;
    assign oMem_We    = mem_we_q;
    assign oMem_Addr  = mem_addr_q;
    assign oMem_Wdata = mem_wdata_q;
    assign oMem_Be    = mem_be_q;
    assign oIRdata    = i_rdata_q;
    assign oIValid    = i_valid_q;
    assign oIErr      = i_err_q;
    assign oDRdata    = d_rdata_q;
    assign oDValid    = d_valid_q;
    assign oDErr      = d_err_q;

endmodule
